// File: rtl/neuron_update_scheduler.sv
// Timestep sequencer for the neuron state register.
// Sweeps every tag through the Izhikevich compute unit (issue, wait for the
// result, write back) and shares the state-register write port with a host
// configuration port that is only served while idle.
module neuron_update_scheduler #(
   parameter int numwidth   = 16,
   parameter int numneurons = 2,
   parameter int tagbits    = 1,
   parameter int stepbits   = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [stepbits-1:0] step_count,
   input  logic                cfg_we,
   input  logic [tagbits-1:0]  cfg_tag,
   input  logic [numwidth:0]   cfg_v,
   input  logic [numwidth:0]   cfg_u,
   output logic                cfg_ready,
   output logic                sr_write_en,
   output logic [tagbits-1:0]  sr_tag,
   output logic [numwidth:0]   sr_v_new,
   output logic [numwidth:0]   sr_u_new,
   input  logic [numwidth:0]   sr_v,
   input  logic [numwidth:0]   sr_u,
   output logic                cu_valid,
   input  logic                cu_ready,
   output logic [tagbits-1:0]  cu_tag,
   output logic [numwidth:0]   cu_v,
   output logic [numwidth:0]   cu_u,
   input  logic                res_valid,
   input  logic [numwidth:0]   res_v,
   input  logic [numwidth:0]   res_u,
   input  logic                res_spike,
   output logic                spike_valid,
   output logic [tagbits-1:0]  spike_tag
);

   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WRITE, DONE} state_t;

   localparam logic [tagbits-1:0] LAST_TAG = tagbits'(numneurons - 1);

   state_t                state_q, state_d;
   logic [tagbits-1:0]    tag_q, tag_d;
   logic [tagbits-1:0]    cu_tag_q;
   logic [numwidth:0]     cu_v_q, cu_u_q;
   logic [numwidth:0]     res_v_q, res_u_q;
   logic                  res_spike_q;
   logic                  first_q;
   logic [stepbits-1:0]   step_q;
   logic                  enter_issue;

   assign enter_issue = (state_d == ISSUE) && (state_q != ISSUE);

   // Next-state and tag sequencing for the sweep.
   always_comb begin
      state_d = state_q;
      tag_d   = tag_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ISSUE;
               tag_d   = '0;
            end
         end
         ISSUE: if (cu_ready) state_d = WAIT;
         WAIT:  if (res_valid) state_d = WRITE;
         WRITE: begin
            tag_d   = tag_q + tagbits'(1);
            state_d = (tag_q == LAST_TAG) ? DONE : ISSUE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State, operand/result capture and timestep counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         cu_tag_q    <= '0;
         cu_v_q      <= '0;
         cu_u_q      <= '0;
         res_v_q     <= '0;
         res_u_q     <= '0;
         res_spike_q <= 1'b0;
         first_q     <= 1'b0;
         step_q      <= '0;
      end else begin
         state_q <= state_d;
         tag_q   <= tag_d;
         first_q <= enter_issue;
         if (enter_issue) cu_tag_q <= tag_d;
         // sr_tag only points at the new tag once ISSUE is entered, so the
         // operands are latched during the first ISSUE cycle.
         if (first_q) begin
            cu_v_q <= sr_v;
            cu_u_q <= sr_u;
         end
         if (state_q == WAIT && res_valid) begin
            res_v_q     <= res_v;
            res_u_q     <= res_u;
            res_spike_q <= res_spike;
         end
         if (state_q == DONE) step_q <= step_q + stepbits'(1);
      end
   end

   // First ISSUE cycle forwards the read data directly; afterwards the
   // latched copy holds the operands stable under backpressure.
   assign cu_v     = first_q ? sr_v : cu_v_q;
   assign cu_u     = first_q ? sr_u : cu_u_q;
   assign cu_tag   = cu_tag_q;
   assign cu_valid = (state_q == ISSUE);

   assign busy       = (state_q != IDLE);
   assign done       = (state_q == DONE);
   assign step_count = step_q;

   // Host owns the write port in IDLE unless a sweep is starting.
   assign cfg_ready   = (state_q == IDLE) && !start;
   assign sr_write_en = (cfg_we && cfg_ready) || (state_q == WRITE);
   assign sr_tag      = (state_q == IDLE) ? cfg_tag : tag_q;
   assign sr_v_new    = (state_q == IDLE) ? cfg_v : res_v_q;
   assign sr_u_new    = (state_q == IDLE) ? cfg_u : res_u_q;

   assign spike_valid = (state_q == WRITE) && res_spike_q;
   assign spike_tag   = (state_q == WRITE) ? tag_q : '0;

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Bench for neuron_update_scheduler: state-register and compute-unit models,
// table-driven host-port vectors, directed sweeps and randomized sweeps
// checked against a per-neuron reference model.
module tb_neuron_update_scheduler;
   localparam int W  = 16;
   localparam int N  = 2;
   localparam int TB = 1;
   localparam int SB = 2;

   logic          clk = 0, reset = 1, start = 0, cfg_we = 0;
   logic [TB-1:0] cfg_tag = '0;
   logic [W:0]    cfg_v = '0, cfg_u = '0;
   logic          busy, done, cfg_ready, sr_write_en, cu_valid, spike_valid;
   logic [SB-1:0] step_count;
   logic [TB-1:0] sr_tag, cu_tag, spike_tag;
   logic [W:0]    sr_v_new, sr_u_new, sr_v, sr_u, cu_v, cu_u;
   logic          cu_ready, res_valid, res_spike;
   logic [W:0]    res_v, res_u;

   neuron_update_scheduler #(.numwidth(W), .numneurons(N), .tagbits(TB), .stepbits(SB)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
      .step_count(step_count), .cfg_we(cfg_we), .cfg_tag(cfg_tag), .cfg_v(cfg_v),
      .cfg_u(cfg_u), .cfg_ready(cfg_ready), .sr_write_en(sr_write_en), .sr_tag(sr_tag),
      .sr_v_new(sr_v_new), .sr_u_new(sr_u_new), .sr_v(sr_v), .sr_u(sr_u),
      .cu_valid(cu_valid), .cu_ready(cu_ready), .cu_tag(cu_tag), .cu_v(cu_v), .cu_u(cu_u),
      .res_valid(res_valid), .res_v(res_v), .res_u(res_u), .res_spike(res_spike),
      .spike_valid(spike_valid), .spike_tag(spike_tag));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // State register: combinational read, write on posedge.
   bit [W:0] mem_v [N];
   bit [W:0] mem_u [N];
   always @(posedge clk) if (sr_write_en) begin
      mem_v[sr_tag] <= sr_v_new;
      mem_u[sr_tag] <= sr_u_new;
   end
   assign sr_v = mem_v[sr_tag];
   assign sr_u = mem_u[sr_tag];

   // Compute-unit knobs, per tag.
   int stall_c [N];
   int delay_c [N];
   bit spike_c [N];
   bit spur_en = 0;

   // Compute unit: stalls cu_ready, returns v+1/u+2 after a delay.
   initial begin : agent
      int ph, cnt;
      logic [W:0] av, au;
      logic [TB-1:0] at;
      ph = 0; cnt = 0; av = '0; au = '0; at = '0;
      cu_ready = 0; res_valid = 0; res_v = '0; res_u = '0; res_spike = 0;
      forever begin
         @(negedge clk);
         res_valid = 0;
         cu_ready  = 0;
         if (!busy || reset) ph = 0;
         if (ph == 0 && cu_valid) begin ph = 1; cnt = 0; end
         if (ph == 1) begin
            if (spur_en && cnt == 0) begin
               res_valid = 1; res_v = '1; res_u = '1; res_spike = 1;
            end
            if (cnt >= stall_c[cu_tag]) begin
               cu_ready = 1; av = cu_v; au = cu_u; at = cu_tag; ph = 2; cnt = 0;
            end else cnt++;
         end else if (ph == 2) begin
            if (cnt >= delay_c[at]) begin
               res_valid = 1;
               res_v = av + (W+1)'(1);
               res_u = au + (W+1)'(2);
               res_spike = spike_c[at];
               ph = 0;
            end else cnt++;
         end
      end
   end

   // Event monitor, cumulative counts only.
   int busy_n = 0, wr_n = 0, done_n = 0, done_cyc = 0, spk_n = 0, spk_bad = 0, stab_err = 0;
   int iss_cyc [$];
   int wr_cyc  [$];
   logic [TB-1:0] iss_tag [$];
   logic [TB-1:0] spk_tag_last = '0;
   logic [W:0] hold_v = '0, hold_u = '0;
   bit cu_prev = 0;
   initial begin : monitor
      forever begin
         @(negedge clk); #2;
         if (busy === 1'b1) busy_n++;
         if (sr_write_en === 1'b1 && busy === 1'b1) begin wr_n++; wr_cyc.push_back(cyc); end
         if (done === 1'b1) begin done_n++; done_cyc = cyc; end
         if (spike_valid === 1'b1) begin
            spk_n++; spk_tag_last = spike_tag;
            if (sr_write_en !== 1'b1 || sr_tag !== spike_tag) spk_bad++;
         end
         if (cu_valid === 1'b1) begin
            if (!cu_prev) begin
               iss_cyc.push_back(cyc); iss_tag.push_back(cu_tag);
               hold_v = cu_v; hold_u = cu_u;
            end else if (cu_v !== hold_v || cu_u !== hold_u) stab_err++;
         end
         cu_prev = (cu_valid === 1'b1);
      end
   end

   int n_chk = 0, n_fail = 0;
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Reference model: per-neuron values and completed timestep count.
   logic [W:0] m_v [N];
   logic [W:0] m_u [N];
   int m_step = 0;

   task automatic check_mem(input string nm);
      for (int i = 0; i < N; i++) begin
         chk({nm, "_v"}, mem_v[i], m_v[i]);
         chk({nm, "_u"}, mem_u[i], m_u[i]);
      end
   endtask

   task automatic host_write(input logic [TB-1:0] t, input logic [W:0] v, input logic [W:0] u);
      @(negedge clk);
      cfg_we = 1; cfg_tag = t; cfg_v = v; cfg_u = u;
      #1;
      chk("host_ready", cfg_ready, 1);
      chk("host_we", sr_write_en, 1);
      m_v[t] = v; m_u[t] = u;
      @(negedge clk);
      cfg_we = 0;
   endtask

   task automatic do_sweep(input string nm, input bit collide, input bit inj, input bit basic);
      int b_wr, b_done, b_spk, b_bad, b_stab, b_iss, b_wrq, b_busy, exp_lat, exp_spk, st_cyc;
      bit got, injd;
      exp_lat = 1; exp_spk = 0;
      for (int i = 0; i < N; i++) begin
         exp_lat += 3 + stall_c[i] + delay_c[i];
         exp_spk += int'(spike_c[i]);
      end
      b_wr = wr_n; b_done = done_n; b_spk = spk_n; b_bad = spk_bad; b_stab = stab_err;
      b_iss = iss_cyc.size(); b_wrq = wr_cyc.size(); b_busy = busy_n;
      @(negedge clk);
      start = 1; st_cyc = cyc;
      if (collide) begin cfg_we = 1; cfg_tag = '0; cfg_v = 17'h0DEAD; cfg_u = 17'h0BEEF; end
      #1;
      if (collide) begin
         chk({nm, "_collide_ready"}, cfg_ready, 0);
         chk({nm, "_collide_we"}, sr_write_en, 0);
      end
      @(negedge clk);
      start = 0; cfg_we = 0;
      got = 0; injd = 0;
      for (int k = 0; k < 400 && !got; k++) begin
         #3;
         start = 0;
         if (done_n > b_done) got = 1;
         else if (inj && !injd && busy && !cu_valid && !sr_write_en && !done) begin
            start = 1; injd = 1;
         end
         @(negedge clk);
      end
      repeat (5) @(negedge clk);
      #3;
      chk({nm, "_timeout"}, got, 1);
      for (int i = 0; i < N; i++) begin
         m_v[i] = m_v[i] + (W+1)'(1);
         m_u[i] = m_u[i] + (W+1)'(2);
      end
      m_step = (m_step + 1) % (1 << SB);
      chk({nm, "_latency"}, done_cyc - st_cyc, exp_lat);
      chk({nm, "_done_pulses"}, done_n - b_done, 1);
      chk({nm, "_writes"}, wr_n - b_wr, N);
      chk({nm, "_issues"}, iss_cyc.size() - b_iss, N);
      chk({nm, "_busy_cycles"}, busy_n - b_busy, exp_lat);
      chk({nm, "_busy_end"}, busy, 0);
      chk({nm, "_spikes"}, spk_n - b_spk, exp_spk);
      chk({nm, "_spike_align"}, spk_bad - b_bad, 0);
      chk({nm, "_operand_stable"}, stab_err - b_stab, 0);
      if (iss_cyc.size() > b_iss) begin
         chk({nm, "_first_issue_cyc"}, iss_cyc[b_iss] - st_cyc, 1);
         chk({nm, "_first_issue_tag"}, iss_tag[b_iss], 0);
      end
      if (basic && wr_cyc.size() >= b_wrq + 2) begin
         chk({nm, "_wr0_cyc"}, wr_cyc[b_wrq] - st_cyc, 3);
         chk({nm, "_wr1_cyc"}, wr_cyc[b_wrq + 1] - st_cyc, 6);
         chk({nm, "_iss1_cyc"}, iss_cyc[b_iss + 1] - st_cyc, 4);
      end
      chk({nm, "_step"}, step_count, m_step);
      check_mem(nm);
   endtask

   typedef struct {
      bit            we;
      logic [TB-1:0] tag;
      logic [W:0]    v, u;
      bit            e_rdy, e_we;
   } vec_t;

   initial begin : main
      vec_t tbl [3];
      bit got;
      int b_wr, b_done, b_iss;
      tbl[0] = '{1'b1, 1'b0, 17'h0FB80, 17'h01F00, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 1'b1, 17'h00100, 17'h00000, 1'b1, 1'b1};
      tbl[2] = '{1'b0, 1'b0, 17'h01234, 17'h05678, 1'b1, 1'b0};
      for (int i = 0; i < N; i++) begin
         m_v[i] = '0; m_u[i] = '0; stall_c[i] = 0; delay_c[i] = 0; spike_c[i] = 0;
      end

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_cu_valid", cu_valid, 0);
      chk("rst_sr_we", sr_write_en, 0);
      chk("rst_spike", spike_valid, 0);
      chk("rst_cu_v", cu_v, 0);
      chk("rst_cu_u", cu_u, 0);
      chk("rst_cu_tag", cu_tag, 0);
      chk("rst_spike_tag", spike_tag, 0);
      chk("rst_step", step_count, 0);
      reset = 0;

      // Host port vectors in IDLE.
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         cfg_we = tbl[i].we; cfg_tag = tbl[i].tag; cfg_v = tbl[i].v; cfg_u = tbl[i].u;
         #1;
         chk("vec_ready", cfg_ready, tbl[i].e_rdy);
         chk("vec_we", sr_write_en, tbl[i].e_we);
         chk("vec_sr_tag", sr_tag, tbl[i].tag);
         chk("vec_sr_v_new", sr_v_new, tbl[i].v);
         if (tbl[i].e_we) begin m_v[tbl[i].tag] = tbl[i].v; m_u[tbl[i].tag] = tbl[i].u; end
         @(posedge clk); #1;
         check_mem("vec_mem");
      end
      @(negedge clk);
      cfg_we = 0;

      // Basic sweep, host write colliding with start.
      do_sweep("basic", 1, 0, 1);
      chk("basic_tag0_v", mem_v[0], 17'h0FB81);
      chk("basic_tag0_u", mem_u[0], 17'h01F02);

      // Backpressure: 5 stall cycles, 4 result-delay cycles on tag0.
      stall_c[0] = 5; delay_c[0] = 4;
      do_sweep("bp", 0, 0, 0);
      stall_c[0] = 0; delay_c[0] = 0;

      // Spike on tag1 only.
      spike_c[1] = 1;
      do_sweep("spike", 0, 0, 0);
      chk("spike_tag", spk_tag_last, 1);
      spike_c[1] = 0;

      // Ignored start in WAIT and spurious res_valid in ISSUE.
      spur_en = 1; stall_c[0] = 2; delay_c[0] = 3;
      do_sweep("ignored", 0, 1, 0);
      spur_en = 0; stall_c[0] = 0; delay_c[0] = 0;
      chk("step_wrap", step_count, 0);

      // Randomized sweeps.
      for (int r = 0; r < 6; r++) begin
         for (int t = 0; t < N; t++)
            host_write(TB'(t), (W+1)'($urandom), (W+1)'($urandom));
         for (int t = 0; t < N; t++) begin
            stall_c[t] = int'($urandom_range(0, 3));
            delay_c[t] = int'($urandom_range(0, 3));
            spike_c[t] = 1'($urandom_range(0, 1));
         end
         do_sweep("rand", 0, 0, 0);
      end
      for (int t = 0; t < N; t++) begin stall_c[t] = 0; delay_c[t] = 0; spike_c[t] = 0; end

      // Reset during WAIT of tag1.
      delay_c[1] = 5;
      b_wr = wr_n; b_done = done_n; b_iss = iss_cyc.size();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
      got = 0;
      for (int k = 0; k < 100 && !got; k++) begin
         #3;
         if (iss_cyc.size() >= b_iss + 2 && busy && !cu_valid && !sr_write_en) got = 1;
         else @(negedge clk);
      end
      chk("rst_mid_timeout", got, 1);
      reset = 1;
      @(negedge clk); #3;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_cu_valid", cu_valid, 0);
      chk("rst_mid_step", step_count, 0);
      chk("rst_mid_writes", wr_n - b_wr, 1);
      chk("rst_mid_done", done_n - b_done, 0);
      m_v[0] = m_v[0] + (W+1)'(1);
      m_u[0] = m_u[0] + (W+1)'(2);
      m_step = 0;
      check_mem("rst_mid_mem");
      reset = 0;
      delay_c[1] = 0;
      do_sweep("post_rst", 0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
